// File: rtl/pd_math_pkg.sv
// Shared defaults for the PD math pipeline plus a signed saturation helper.
package pd_math_pkg;

    localparam int ERR_W_DEF   = 16;
    localparam int SAT_W_DEF   = 10;
    localparam int Q_DEPTH_DEF = 12;
    localparam int D_SAT_W_DEF = 7;
    localparam int P_NUM_DEF   = 5;
    localparam int P_SHIFT_DEF = 3;
    localparam int D_COEFF_DEF = 7;
    localparam int PID_W_DEF   = 14;

    // Clamp a signed value into the range representable by a signed field of the given width.
    function automatic int satToWidth(input int value, input int width);
        int maxVal;
        int minVal;
        maxVal = (1 << (width - 1)) - 1;
        minVal = -(1 << (width - 1));
        if (value > maxVal) begin
            return maxVal;
        end
        if (value < minVal) begin
            return minVal;
        end
        return value;
    endfunction

endpackage

// File: rtl/err_hist_q.sv
// Circular history of saturated errors; exposes the entry written DEPTH pushes ago.
module err_hist_q
    import pd_math_pkg::*;
#(
    parameter int DEPTH = Q_DEPTH_DEF,
    parameter int WIDTH = SAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] oldest,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] fill_q;

    // Write at the pointer, wrap at DEPTH, and count pushes up to DEPTH; flush behaves like reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            fill_q  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            fill_q  <= '0;
        end else if (push) begin
            mem_q[wrPtr_q] <= din;
            wrPtr_q <= (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
            if (fill_q != CNT_W'(DEPTH)) begin
                fill_q <= fill_q + CNT_W'(1);
            end
        end
    end

    // The slot about to be overwritten holds the sample from exactly DEPTH pushes back (zero after a clear).
    assign oldest = mem_q[wrPtr_q];
    assign full   = (fill_q == CNT_W'(DEPTH));

endmodule

// File: rtl/pd_math_q.sv
// Two-stage P+D term: saturate the error, then combine it with its delayed copy.
module pd_math_q
    import pd_math_pkg::*;
#(
    parameter int ERR_W   = ERR_W_DEF,
    parameter int SAT_W   = SAT_W_DEF,
    parameter int Q_DEPTH = Q_DEPTH_DEF,
    parameter int D_SAT_W = D_SAT_W_DEF,
    parameter int P_NUM   = P_NUM_DEF,
    parameter int P_SHIFT = P_SHIFT_DEF,
    parameter int D_COEFF = D_COEFF_DEF,
    parameter int PID_W   = PID_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld,
    input  logic                    clr,
    input  logic signed [ERR_W-1:0] actual,
    input  logic signed [ERR_W-1:0] desired,
    output logic                    out_vld,
    output logic signed [PID_W-1:0] pid,
    output logic                    q_full
);

    logic signed [SAT_W-1:0]   errSat_q;
    logic signed [SAT_W-1:0]   errSat_d;
    logic                      s1Vld_q;
    logic signed [SAT_W-1:0]   oldest;
    logic signed [D_SAT_W-1:0] dDiff;
    int                        pTerm;
    int                        dTerm;
    logic signed [PID_W-1:0]   pid_d;
    logic signed [PID_W-1:0]   pid_q;
    logic                      outVld_q;
    logic                      histPush;

    // Error saturation for stage 1 and the P/D arithmetic for stage 2, all at full integer precision.
    always_comb begin
        errSat_d = SAT_W'(satToWidth(int'(actual) - int'(desired), SAT_W));
        dDiff    = D_SAT_W'(satToWidth(int'(errSat_q) - int'(oldest), D_SAT_W));
        pTerm    = (int'(errSat_q) * P_NUM) >>> P_SHIFT;
        dTerm    = int'(dDiff) * D_COEFF;
        pid_d    = PID_W'(pTerm + dTerm);
    end

    // Stage 1 captures the saturated error; a clear drops whatever sample arrives with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errSat_q <= '0;
            s1Vld_q  <= 1'b0;
        end else if (clr) begin
            s1Vld_q  <= 1'b0;
        end else begin
            s1Vld_q <= vld;
            if (vld) begin
                errSat_q <= errSat_d;
            end
        end
    end

    // Stage 2 registers pid and pulses out_vld; a clear kills the in-flight sample but keeps pid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pid_q    <= '0;
            outVld_q <= 1'b0;
        end else if (clr) begin
            outVld_q <= 1'b0;
        end else begin
            outVld_q <= s1Vld_q;
            if (s1Vld_q) begin
                pid_q <= pid_d;
            end
        end
    end

    assign histPush = s1Vld_q & ~clr;

    err_hist_q #(
        .DEPTH (Q_DEPTH),
        .WIDTH (SAT_W)
    ) u_hist (
        .clk    (clk),
        .rst    (rst),
        .push   (histPush),
        .flush  (clr),
        .din    (errSat_q),
        .oldest (oldest),
        .full   (q_full)
    );

    assign pid     = pid_q;
    assign out_vld = outVld_q;

endmodule

// File: tb/tb_pd_math_q.sv
// Self-checking bench for pd_math_q: directed scenarios plus randomized traffic against a queue-based model.
module tb_pd_math_q;

    localparam int ERR_W   = 16;
    localparam int SAT_W   = 10;
    localparam int QD      = 12;
    localparam int D_SAT_W = 7;
    localparam int P_NUM   = 5;
    localparam int P_SHIFT = 3;
    localparam int D_COEFF = 7;
    localparam int PID_W   = 14;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    vld = 1'b0;
    logic                    clr = 1'b0;
    logic signed [ERR_W-1:0] actual = '0;
    logic signed [ERR_W-1:0] desired = '0;
    logic                    out_vld;
    logic signed [PID_W-1:0] pid;
    logic                    q_full;

    typedef struct {
        int due;
        int pid;
    } pend_t;

    pend_t pendQ[$];
    int    hist[$];
    int    cycleNo   = 0;
    int    lastPid   = 0;
    int    completed = 0;
    int    checks    = 0;
    int    errors    = 0;

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    pd_math_q dut (
        .clk     (clk),
        .rst     (rst),
        .vld     (vld),
        .clr     (clr),
        .actual  (actual),
        .desired (desired),
        .out_vld (out_vld),
        .pid     (pid),
        .q_full  (q_full)
    );

    function automatic int clampW(input int v, input int w);
        int hi;
        int lo;
        hi = (2 ** (w - 1)) - 1;
        lo = -(2 ** (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int floorDiv(input int n, input int dv);
        int q;
        q = n / dv;
        if ((n % dv != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: pid for a new sample given every error accepted since the last clear.
    function automatic int refPid(input int a, input int d);
        int e;
        int old;
        int n;
        e   = clampW(a - d, SAT_W);
        n   = hist.size();
        old = (n >= QD) ? hist[n - QD] : 0;
        hist.push_back(e);
        return floorDiv(e * P_NUM, 2 ** P_SHIFT) + clampW(e - old, D_SAT_W) * D_COEFF;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d observed %0d expected %0d", tag, cycleNo, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic c, input int a, input int d);
        pend_t p;
        int    expVld;
        vld     = v;
        clr     = c;
        actual  = ERR_W'(a);
        desired = ERR_W'(d);
        @(posedge clk);
        #1;
        cycleNo++;
        if (c) begin
            pendQ.delete();
            hist.delete();
            completed = 0;
        end else if (v) begin
            p.due = cycleNo + 1;
            p.pid = refPid(a, d);
            pendQ.push_back(p);
        end
        expVld = 0;
        if (pendQ.size() > 0 && pendQ[0].due == cycleNo) begin
            lastPid = pendQ[0].pid;
            void'(pendQ.pop_front());
            completed++;
            expVld = 1;
        end
        checkOutput("out_vld", 32'(out_vld), expVld);
        checkOutput("pid", 32'(pid), lastPid);
        checkOutput("q_full", 32'(q_full), (completed >= QD) ? 1 : 0);
    endtask

    task automatic doReset();
        vld = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        #2;
        checkOutput("rst_pid", 32'(pid), 0);
        checkOutput("rst_out_vld", 32'(out_vld), 0);
        checkOutput("rst_q_full", 32'(q_full), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycleNo++;
        pendQ.delete();
        hist.delete();
        completed = 0;
        lastPid   = 0;
    endtask

    // Directed scenarios followed by randomized traffic, then the summary.
    initial begin
        int r;
        int a;
        int d;
        #1;
        doReset();

        // Positive full-scale error saturates both P and D paths.
        applyStimulus(1'b1, 1'b0, 32767, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("fullscale_pid", 32'(pid), 760);

        // Constant error over the full history depth and one sample beyond.
        doReset();
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b0, 100, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("wrap_pid", 32'(pid), 62);
        checkOutput("wrap_q_full", 32'(q_full), 1);
        applyStimulus(1'b0, 1'b0, 0, 0);

        // Negative error exercises the floor shift.
        doReset();
        applyStimulus(1'b1, 1'b0, 0, 100);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("neg_pid", 32'(pid), -511);

        // Clear arriving together with a sample.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 100, 0);
        applyStimulus(1'b1, 1'b1, 100, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b0, 100, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        checkOutput("clr_pid", 32'(pid), 503);
        checkOutput("clr_q_full", 32'(q_full), 0);

        // Sparse samples with idle gaps.
        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, 1'b0, 100, 0);
            for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 0, 0);
        end
        checkOutput("sparse_pid", 32'(pid), 62);

        // Randomized traffic with occasional clears and one mid-stream reset.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) doReset();
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 1) == 1) begin
                a = int'($urandom_range(0, 600)) - 300;
                d = int'($urandom_range(0, 600)) - 300;
            end else begin
                a = int'($urandom_range(0, 65535)) - 32768;
                d = int'($urandom_range(0, 65535)) - 32768;
            end
            applyStimulus(r < 65, r < 3, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pd_math_q.md
PD_MATH_Q -- requirements
Module: pd_math_q

Interface
REQ-001 SHALL have parameter ERR_W, default 16: signed width of actual/desired inputs.
REQ-002 SHALL have parameter SAT_W, default 10: signed width of saturated error.
REQ-003 SHALL have parameter Q_DEPTH, default 12, legal range 2..32: derivative history depth in valid samples.
REQ-004 SHALL have parameter D_SAT_W, default 7: signed width of saturated derivative difference.
REQ-005 SHALL have parameters P_NUM=5, P_SHIFT=3, D_COEFF=7: proportional gain P_NUM/2^P_SHIFT; derivative gain D_COEFF.
REQ-006 SHALL have parameter PID_W, default 14: signed output width.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 vld  input  1  sample strobe, one sample per high cycle.
REQ-010 clr  input  1  synchronous flush of history and pipeline, e.g. during inertial calibration.
REQ-011 actual  input  ERR_W  signed measured value.
REQ-012 desired  input  ERR_W  signed setpoint.
REQ-013 out_vld  output  1  pid valid, one-cycle pulse per accepted sample.
REQ-014 pid  output  PID_W  signed P+D term, held between pulses.
REQ-015 q_full  output  1  high once Q_DEPTH samples have been pushed since the last reset/clr.

Function
REQ-016 Stage 1, on vld: err = actual - desired computed in ERR_W+1 bits, saturated to SAT_W signed range [-2^(SAT_W-1), 2^(SAT_W-1)-1], registered.
REQ-017 Stage 2: d_diff = err_sat - oldest history entry in SAT_W+1 bits, saturated to D_SAT_W signed.
REQ-018 Oldest entry SHALL be the err_sat pushed exactly Q_DEPTH accepted samples earlier; zero if fewer than Q_DEPTH pushes since reset/clr.
REQ-019 History SHALL be a circular buffer of Q_DEPTH SAT_W-bit entries; write pointer wraps Q_DEPTH-1 -> 0; pointer advances and err_sat is pushed only when stage 2 consumes a valid sample.
REQ-020 p_term = (err_sat * P_NUM) >>> P_SHIFT, arithmetic (floor) shift, full precision.
REQ-021 d_term = d_diff * D_COEFF, full precision.
REQ-022 pid = sign-extended p_term + d_term, registered; no output saturation.
REQ-023 Latency: out_vld and new pid SHALL appear exactly 2 cycles after the vld cycle; back-to-back vld SHALL give back-to-back out_vld.
REQ-024 Cycles without vld SHALL NOT advance history, fill count or pid.
REQ-025 Fill counter SHALL saturate at Q_DEPTH; q_full asserts in the cycle after the Q_DEPTH-th push.
REQ-026 clr SHALL, next edge: zero all history entries, write pointer, fill counter, both stage valids; q_full low; out_vld low; pid holds.
REQ-027 clr and vld in the same cycle: clr wins, sample discarded.
REQ-028 In-flight samples at clr SHALL be discarded and SHALL NOT produce out_vld.

Reset
REQ-029 rst SHALL asynchronously force: pid=0, out_vld=0, q_full=0, err register=0, all history=0, pointer=0, fill counter=0, stage valids=0.
REQ-030 Deassertion mid-stream SHALL restart as from clr; the first sample after it behaves as a first sample.

Structure
REQ-031 Default gains, widths and Q_DEPTH SHALL live in shared package pd_math_pkg, together with a saturate-to-width function.
REQ-032 History buffer SHALL be sub-module err_hist_q (parameters DEPTH, WIDTH; ports push, flush, din, oldest, full).

Verification (defaults)
REQ-033 Reset: rst high, then low -> pid=0, out_vld=0, q_full=0.
REQ-034 actual=16'h7FFF, desired=0, one vld -> 2 cycles later out_vld=1, pid=760 (P 319 + D 63*7=441).
REQ-035 err=+100 on 13 consecutive vld cycles -> pid=503 for samples 1..12; q_full high after push 12; sample 13 pid=62.
REQ-036 actual=0, desired=16'h0064, one vld -> pid=-511 (P -63, D -64*7=-448).
REQ-037 5 vld at err=100, clr asserted with a 6th vld, then vld at err=100 -> no out_vld for the 6th sample, q_full=0, next pid=503.
REQ-038 err=100 vld pulses separated by 3 idle cycles, 13 samples -> identical results to REQ-035; pid stable during idle cycles.
